load_store_unit: RTL and testbench

- Data-memory stage directly downstream of the single-cycle CPU's ALU.
- Takes the ALU result as the byte address, plus the decoded memory command, access size and store data.
- Runs a req/ack handshake with a word-wide data memory that has byte enables, and stalls the CPU until the access completes.
- Returns load data aligned and extended for the register write-back mux.

---
 rtl/load_store_unit_pkg.sv | 37 +++
 rtl/load_store_unit_load_align.sv | 31 +++
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 tb/tb_load_store_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// +----------------------------------------------------------------------------+
// | load_store_unit_pkg : shared encodings for the data-memory stage           |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package load_store_unit_pkg;

  localparam int W_MEM_CMD = 2;
  localparam logic [W_MEM_CMD-1:0] MEM_CMD_NOP   = 2'd0;
  localparam logic [W_MEM_CMD-1:0] MEM_CMD_READ  = 2'd1;
  localparam logic [W_MEM_CMD-1:0] MEM_CMD_WRITE = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [31:0] LSU_DEADBEEF = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  // Size code 3 is handled as a word access.
  function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] k);
    case (sz)
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = ~k[0];
      default: is_aligned = (k == 2'd0);
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_load_align.sv
// +----------------------------------------------------------------------------+
// | lsu_load_align : shifts the addressed lane down and sign/zero extends it   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  k,
  input  logic [1:0]  size,
  input  logic        ld_signed,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {k, 3'b000};
    result  = shifted;
    case (size)
      SZ_BYTE: result = {{24{ld_signed & shifted[7]}}, shifted[7:0]};
      SZ_HALF: result = {{16{ld_signed & shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// +----------------------------------------------------------------------------+
// | load_store_unit : req/ack data-memory stage with byte lanes and CPU stall  |
// | Optional macro LSU_TIMEOUT_EN adds an ack timeout with bus_err reporting.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int W_ADDR      = 32,
  parameter int W_DATA      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [W_MEM_CMD-1:0] mem_cmd,
  input  logic [1:0]           size,
  input  logic                 ld_signed,
  input  logic [W_ADDR-1:0]    addr,
  input  logic [W_DATA-1:0]    wdata,
  output logic                 stall,
  output logic [W_DATA-1:0]    rdata,
  output logic                 rdata_valid,
  output logic                 misalign,
  output logic                 bus_err,
  output logic                 m_req,
  output logic                 m_we,
  output logic [W_ADDR-3:0]    m_addr,
  output logic [3:0]           m_be,
  output logic [W_DATA-1:0]    m_wdata,
  input  logic                 m_ack,
  input  logic [W_DATA-1:0]    m_rdata
);

  lsu_state_e  state;
  logic [1:0]  k;
  logic        active;
  logic        aligned;
  logic        start;
  logic [3:0]  be_next;
  logic [W_DATA-1:0] wdata_next;
  logic [1:0]  k_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [W_DATA-1:0] load_word;

  assign k       = addr[1:0];
  assign active  = (state == LSU_IDLE) && req_valid && (mem_cmd != MEM_CMD_NOP);
  assign aligned = is_aligned(size, k);
  assign start   = active & aligned;

  // Gated by reset so that a reset mid-access drops the stall immediately.
  assign stall    = rst & (start | (state == LSU_REQ));
  assign misalign = rst & active & ~aligned;

  always_comb begin
    be_next    = 4'hF;
    wdata_next = wdata;
    if (mem_cmd == MEM_CMD_WRITE) begin
      case (size)
        SZ_BYTE: begin
          be_next    = 4'b0001 << k;
          wdata_next = {4{wdata[7:0]}};
        end
        SZ_HALF: begin
          be_next    = 4'b0011 << k;
          wdata_next = {2{wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  lsu_load_align u_load_align (
    .word      (m_rdata),
    .k         (k_q),
    .size      (size_q),
    .ld_signed (signed_q),
    .result    (load_word)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int W_CNT = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [W_CNT-1:0] cnt;
  logic             expired;

  assign expired = (cnt == W_CNT'(TIMEOUT_CYC - 1));
`else
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= LSU_IDLE;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      m_req       <= 1'b0;
      m_we        <= 1'b0;
      m_addr      <= '0;
      m_be        <= '0;
      m_wdata     <= '0;
      k_q         <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      bus_err     <= 1'b0;
      cnt         <= '0;
`endif
    end else begin
      rdata_valid <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      bus_err     <= 1'b0;
`endif
      case (state)
        LSU_IDLE: begin
          if (start) begin
            state    <= LSU_REQ;
            m_req    <= 1'b1;
            m_we     <= (mem_cmd == MEM_CMD_WRITE);
            m_addr   <= addr[W_ADDR-1:2];
            m_be     <= be_next;
            m_wdata  <= wdata_next;
            k_q      <= k;
            size_q   <= size;
            signed_q <= ld_signed;
`ifdef LSU_TIMEOUT_EN
            cnt      <= '0;
`endif
          end
        end
        LSU_REQ: begin
          if (m_ack) begin
            state <= LSU_DONE;
            m_req <= 1'b0;
            if (!m_we) begin
              rdata       <= load_word;
              rdata_valid <= 1'b1;
            end
          end
`ifdef LSU_TIMEOUT_EN
          else if (expired) begin
            state   <= LSU_DONE;
            m_req   <= 1'b0;
            bus_err <= 1'b1;
            if (!m_we) begin
              rdata       <= LSU_DEADBEEF;
              rdata_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        // The CPU advances at this edge; its still-presented request is not restarted.
        LSU_DONE: state <= LSU_IDLE;
        default:  state <= LSU_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// +----------------------------------------------------------------------------+
// | tb_load_store_unit : directed and random checks against a lane-level model |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  mem_cmd = 2'd0;
  logic [1:0]  size = 2'd0;
  logic        ld_signed = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall, rdata_valid, misalign, bus_err, m_req, m_we;
  logic [31:0] rdata, m_wdata;
  logic [29:0] m_addr;
  logic [3:0]  m_be;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = '0;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] mem [0:255];
  logic [31:0] last_rd = '0;

  always #5 clk = ~clk;

  load_store_unit #(.W_ADDR(32), .W_DATA(32), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .mem_cmd(mem_cmd), .size(size),
    .ld_signed(ld_signed), .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
    .rdata_valid(rdata_valid), .misalign(misalign), .bus_err(bus_err), .m_req(m_req),
    .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata), .m_ack(m_ack),
    .m_rdata(m_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_misaligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                             input logic sgn, input logic [31:0] a);
    logic [31:0] v;
    v = word >> (8 * (a % 4));
    if (sz == 2'd0) begin
      v = v % 256;
      if (sgn && v >= 128) v = v - 32'd256;
    end else if (sz == 2'd1) begin
      v = v % 65536;
      if (sgn && v >= 32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  task automatic do_op(input logic [1:0] cmd, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] a, input logic [31:0] wd, input int dly);
    bit is_ld;
    int kk;
    logic [31:0] exp_be, exp_wd, exp_rd, msk;
    is_ld = (cmd == MEM_CMD_READ);
    kk    = a % 4;
    @(negedge clk);
    req_valid = 1'b1; mem_cmd = cmd; size = sz; ld_signed = sgn; addr = a; wdata = wd;
    #1;
    if (model_misaligned(sz, a)) begin
      chk("mis_flag", {31'd0, misalign}, 32'd1);
      chk("mis_stall", {31'd0, stall}, 32'd0);
      chk("mis_mreq", {31'd0, m_req}, 32'd0);
      @(negedge clk);
      req_valid = 1'b0; mem_cmd = MEM_CMD_NOP;
      #1;
      chk("mis_pulse_end", {31'd0, misalign}, 32'd0);
      chk("mis_mreq_after", {31'd0, m_req}, 32'd0);
      return;
    end
    chk("start_stall", {31'd0, stall}, 32'd1);
    chk("start_misalign", {31'd0, misalign}, 32'd0);
    if (is_ld) begin
      exp_be = 32'd15; exp_wd = wd;
    end else if (sz == 2'd0) begin
      exp_be = 32'd1 * (2 ** kk); exp_wd = (wd % 256) * 32'h0101_0101;
    end else if (sz == 2'd1) begin
      exp_be = 32'd3 * (2 ** kk); exp_wd = (wd % 65536) * 32'h0001_0001;
    end else begin
      exp_be = 32'd15; exp_wd = wd;
    end
    exp_rd = model_load(mem[a[9:2]], sz, sgn, a);
    for (int cyc = 0; cyc <= dly; cyc++) begin
      @(negedge clk);
      #1;
      chk("req_mreq", {31'd0, m_req}, 32'd1);
      chk("req_stall", {31'd0, stall}, 32'd1);
      chk("req_maddr", {2'b00, m_addr}, a / 4);
      chk("req_mbe", {28'd0, m_be}, exp_be);
      chk("req_mwe", {31'd0, m_we}, {31'd0, !is_ld});
      if (!is_ld) chk("req_mwdata", m_wdata, exp_wd);
      if (cyc == dly) begin
        m_ack = 1'b1;
        m_rdata = mem[a[9:2]];
        if (!is_ld) begin
          for (int j = 0; j < 4; j++) begin
            msk = 32'hFF << (8 * j);
            if (exp_be[j]) mem[a[9:2]] = (mem[a[9:2]] & ~msk) | (exp_wd & msk);
          end
        end
      end else begin
        m_rdata = $urandom;
      end
    end
    @(negedge clk);
    m_ack = 1'b0;
    #1;
    chk("done_stall", {31'd0, stall}, 32'd0);
    chk("done_mreq", {31'd0, m_req}, 32'd0);
    chk("done_rvalid", {31'd0, rdata_valid}, {31'd0, is_ld});
    chk("done_buserr", {31'd0, bus_err}, 32'd0);
    if (is_ld) last_rd = exp_rd;
    chk("done_rdata", rdata, last_rd);
    @(negedge clk);
    req_valid = 1'b0; mem_cmd = MEM_CMD_NOP;
    #1;
    chk("after_norestart", {31'd0, m_req}, 32'd0);
    chk("after_rvalid", {31'd0, rdata_valid}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rvalid", {31'd0, rdata_valid}, 32'd0);
    chk("rst_mreq", {31'd0, m_req}, 32'd0);
    chk("rst_mbe", {28'd0, m_be}, 32'd0);
    chk("rst_buserr", {31'd0, bus_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed loads
    mem[64] = 32'h1122_3344;
    do_op(MEM_CMD_READ, SZ_WORD, 1'b0, 32'h100, 32'd0, 0);
    chk("lw_const", rdata, 32'h1122_3344);
    mem[64] = 32'h80FF_0000;
    do_op(MEM_CMD_READ, SZ_BYTE, 1'b1, 32'h103, 32'd0, 1);
    chk("lb_signed_const", rdata, 32'hFFFF_FF80);
    do_op(MEM_CMD_READ, SZ_BYTE, 1'b0, 32'h103, 32'd0, 2);
    chk("lbu_const", rdata, 32'h0000_0080);
    do_op(MEM_CMD_READ, SZ_HALF, 1'b1, 32'h102, 32'd0, 0);
    chk("lh_signed_const", rdata, 32'hFFFF_80FF);

    // Directed store and misaligned accesses
    do_op(MEM_CMD_WRITE, SZ_BYTE, 1'b0, 32'h201, 32'h0000_00AB, 1);
    do_op(MEM_CMD_WRITE, SZ_HALF, 1'b0, 32'h203, 32'h1234_5678, 0);
    do_op(MEM_CMD_READ, SZ_WORD, 1'b0, 32'h102, 32'd0, 0);

    // Idle inputs: NOP and req_valid low
    @(negedge clk);
    req_valid = 1'b1; mem_cmd = MEM_CMD_NOP; addr = 32'h100;
    #1;
    chk("nop_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0; mem_cmd = MEM_CMD_READ;
    #1;
    chk("novalid_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    #1;
    chk("idle_mreq", {31'd0, m_req}, 32'd0);
    mem_cmd = MEM_CMD_NOP;

    // Reset asserted in the third REQ cycle of a slow access
    @(negedge clk);
    req_valid = 1'b1; mem_cmd = MEM_CMD_READ; size = SZ_WORD; addr = 32'h100;
    repeat (3) @(negedge clk);
    #1;
    chk("rstmid_mreq_before", {31'd0, m_req}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rstmid_mreq", {31'd0, m_req}, 32'd0);
    chk("rstmid_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; mem_cmd = MEM_CMD_NOP;
    last_rd = 32'd0;
    @(negedge clk);
    #1;
    chk("rstmid_idle_mreq", {31'd0, m_req}, 32'd0);
    do_op(MEM_CMD_READ, SZ_WORD, 1'b0, 32'h100, 32'd0, 0);

`ifdef LSU_TIMEOUT_EN
    begin
      int waited;
      @(negedge clk);
      req_valid = 1'b1; mem_cmd = MEM_CMD_READ; size = SZ_WORD; addr = 32'h0;
      @(negedge clk);
      #1;
      waited = 0;
      while (m_req === 1'b1 && waited < 50) begin
        waited++;
        @(negedge clk);
        #1;
      end
      chk("tmo_cycles", waited, TMO);
      chk("tmo_buserr", {31'd0, bus_err}, 32'd1);
      chk("tmo_rdata", rdata, 32'hDEAD_BEEF);
      chk("tmo_rvalid", {31'd0, rdata_valid}, 32'd1);
      chk("tmo_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      req_valid = 1'b0; mem_cmd = MEM_CMD_NOP;
      #1;
      chk("tmo_buserr_pulse", {31'd0, bus_err}, 32'd0);
      last_rd = 32'hDEAD_BEEF;
    end
`endif

    // Random traffic against the lane model
    for (int n = 0; n < 200; n++) begin
      do_op(($urandom_range(0, 1) != 0) ? MEM_CMD_READ : MEM_CMD_WRITE,
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 1023)), $urandom, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
